// File: rtl/protocol_pkg.sv
// Host-command field selectors for per-voice parameter writes.
package protocol_pkg;
    localparam int unsigned FIELD_W = 3;
    localparam int unsigned CMD_W   = 8;

    typedef enum logic [FIELD_W-1:0] {
        FREQ    = 3'd0,
        AMP     = 3'd1,
        SHAPE   = 3'd2,
        ENABLE  = 3'd3,
        CMD     = 3'd4,
        CLR_OVR = 3'd5
    } voice_field_t;
endpackage

// File: rtl/shape_pkg.sv
// Oscillator waveform shapes, shared by the sequencer and the oscillator bank.
package shape_pkg;
    localparam int unsigned SHAPE_W = 2;

    typedef enum logic [SHAPE_W-1:0] {
        SAWTOOTH = 2'd0,
        SQUARE   = 2'd1,
        TRIANGLE = 2'd2,
        SINE     = 2'd3
    } wave_shape;
endpackage

// File: rtl/constants.svh
// Shared build constants for the oscillator bank and its sequencer.
//   FIXED_POINT        : fractional bits appended to the voice amplitude width
//   N_OSCILLATORS      : number of voices in the bank
//   ENVELOPE_RESET_BIT : bit of the one-shot command byte that restarts an envelope
`ifndef WAVEGEN_CONSTANTS_SVH
`define WAVEGEN_CONSTANTS_SVH
`define FIXED_POINT 8
`define N_OSCILLATORS 4
`define ENVELOPE_RESET_BIT 7
`endif

// File: rtl/wavegen_sequencer_voice_regfile.sv
// Per-voice parameter storage with host write decode, pending one-shot
// command set/clear and a read mux addressed by the sweep index.
// Ports:
//   clk, rstn            clock, async active-low reset
//   wr_en/voice/field/data host write port
//   slot_en              high while a voice slot is being swept; clears that
//                        voice's pending commands at the slot-ending edge
//   rd_index             addressed voice (N_WAVEGENS = idle, reads as zero)
//   rd_*_c               combinational parameters of rd_index
//   ovr_clear_c          host requested overrun clear
`include "constants.svh"

module wavegen_sequencer_voice_regfile
    import shape_pkg::*;
    import protocol_pkg::*;
#(
    parameter int unsigned WIDTH      = 24,
    parameter int unsigned N_WAVEGENS = `N_OSCILLATORS,
    localparam int unsigned VW        = $clog2(N_WAVEGENS),
    localparam int unsigned IW        = $clog2(N_WAVEGENS + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [VW-1:0]    wr_voice,
    input  logic [2:0]       wr_field,
    input  logic [31:0]      wr_data,
    input  logic             slot_en,
    input  logic [IW-1:0]    rd_index,
    output logic             rd_enable_c,
    output logic [7:0]       rd_cmds_c,
    output logic [31:0]      rd_freq_c,
    output logic [WIDTH-1:0] rd_amp_c,
    output wave_shape        rd_shape_c,
    output logic             ovr_clear_c
);

    logic [31:0]      freq_q   [N_WAVEGENS];
    logic [WIDTH-1:0] amp_q    [N_WAVEGENS];
    wave_shape        shape_q  [N_WAVEGENS];
    logic             enable_q [N_WAVEGENS];
    logic [7:0]       cmds_q   [N_WAVEGENS];

    voice_field_t          field;
    logic [N_WAVEGENS-1:0] wr_hit;
    logic [N_WAVEGENS-1:0] slot_end;

    assign field       = voice_field_t'(wr_field);
    assign ovr_clear_c = wr_en && (field == CLR_OVR);

    // Per-voice write select and end-of-slot strobe
    always_comb begin
        wr_hit   = '0;
        slot_end = '0;
        for (int v = 0; v < int'(N_WAVEGENS); v++) begin
            wr_hit[v]   = wr_en && (wr_voice == VW'(v));
            slot_end[v] = slot_en && (rd_index == IW'(v));
        end
    end

    // Storage; a CMD write on a voice's own slot-ending edge replaces the
    // clear so the new bits survive into the next frame
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int v = 0; v < int'(N_WAVEGENS); v++) begin
                freq_q[v]   <= '0;
                amp_q[v]    <= '0;
                shape_q[v]  <= SAWTOOTH;
                enable_q[v] <= 1'b0;
                cmds_q[v]   <= '0;
            end
        end else begin
            for (int v = 0; v < int'(N_WAVEGENS); v++) begin
                if (slot_end[v]) begin
                    cmds_q[v] <= '0;
                end
                if (wr_hit[v]) begin
                    case (field)
                        FREQ:    freq_q[v]   <= wr_data;
                        AMP:     amp_q[v]    <= wr_data[WIDTH-1:0];
                        SHAPE:   shape_q[v]  <= wave_shape'(wr_data[SHAPE_W-1:0]);
                        ENABLE:  enable_q[v] <= wr_data[0];
                        CMD:     cmds_q[v]   <= (slot_end[v] ? 8'h00 : cmds_q[v]) | wr_data[7:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Read mux; the idle slot presents all-zero parameters
    always_comb begin
        rd_enable_c = 1'b0;
        rd_cmds_c   = '0;
        rd_freq_c   = '0;
        rd_amp_c    = '0;
        rd_shape_c  = SAWTOOTH;
        if (rd_index < IW'(N_WAVEGENS)) begin
            rd_enable_c = enable_q[rd_index[VW-1:0]];
            rd_cmds_c   = cmds_q[rd_index[VW-1:0]];
            rd_freq_c   = freq_q[rd_index[VW-1:0]];
            rd_amp_c    = amp_q[rd_index[VW-1:0]];
            rd_shape_c  = shape_q[rd_index[VW-1:0]];
        end
    end

endmodule

// File: rtl/wavegen_sequencer.sv
// Frame sequencer for the time-multiplexed oscillator bank: on each sample
// tick it sweeps osc_index over all voices, presents each voice's
// parameters, accumulates the returned samples and publishes one mixed
// sample per frame.
// Ports:
//   clk, rstn               clock, async active-low reset
//   sample_tick             frame start pulse
//   wr_*                    host parameter writes
//   osc_index, osc_*        addressed voice and its parameters (to oscillator)
//   osc_out, osc_enabled    oscillator sample / envelope-active for osc_index
//   mix_out, mix_valid      mixed frame sample and its one-cycle strobe
//   active_mask             per-voice envelope-active flags from the last sweep
//   overrun                 sticky: tick arrived while a frame was in flight
// Build option: MIX_SATURATE_EN -- mix_out is the accumulator clipped to the
// output range instead of the accumulator averaged over the voice count.
`include "constants.svh"

module wavegen_sequencer
    import shape_pkg::*;
    import protocol_pkg::*;
#(
    parameter int unsigned WIDTH      = 24,
    parameter int unsigned N_WAVEGENS = `N_OSCILLATORS,
    localparam int unsigned VW        = $clog2(N_WAVEGENS),
    localparam int unsigned IW        = $clog2(N_WAVEGENS + 1),
    localparam int unsigned LOG_N     = $clog2(N_WAVEGENS),
    localparam int unsigned OW        = WIDTH + `FIXED_POINT,
    localparam int unsigned AW        = OW + LOG_N
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sample_tick,
    input  logic                  wr_en,
    input  logic [VW-1:0]         wr_voice,
    input  logic [2:0]            wr_field,
    input  logic [31:0]           wr_data,
    output logic [IW-1:0]         osc_index,
    output logic                  osc_enable,
    output logic [7:0]            osc_cmds,
    output logic [31:0]           osc_freq,
    output logic [WIDTH-1:0]      osc_amplitude,
    output wave_shape             osc_shape,
    input  logic signed [OW-1:0]  osc_out,
    input  logic                  osc_enabled,
    output logic signed [OW-1:0]  mix_out,
    output logic                  mix_valid,
    output logic [N_WAVEGENS-1:0] active_mask,
    output logic                  overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SWEEP   = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    state_t               state;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] voice_term;
    logic signed [OW-1:0] mix_next;
    logic                 ovr_clear_c;

    wavegen_sequencer_voice_regfile #(
        .WIDTH      (WIDTH),
        .N_WAVEGENS (N_WAVEGENS)
    ) u_regfile (
        .clk         (clk),
        .rstn        (rstn),
        .wr_en       (wr_en),
        .wr_voice    (wr_voice),
        .wr_field    (wr_field),
        .wr_data     (wr_data),
        .slot_en     (state == SWEEP),
        .rd_index    (osc_index),
        .rd_enable_c (osc_enable),
        .rd_cmds_c   (osc_cmds),
        .rd_freq_c   (osc_freq),
        .rd_amp_c    (osc_amplitude),
        .rd_shape_c  (osc_shape),
        .ovr_clear_c (ovr_clear_c)
    );

    // Sign-extended contribution of the addressed voice; disabled voices add zero
    assign voice_term = osc_enable ? {{LOG_N{osc_out[OW-1]}}, osc_out} : '0;

`ifdef MIX_SATURATE_EN
    localparam logic signed [AW-1:0] SAT_MAX = AW'({1'b0, {(OW-1){1'b1}}});
    localparam logic signed [AW-1:0] SAT_MIN = {{(LOG_N+1){1'b1}}, {(OW-1){1'b0}}};

    // Clip the full-precision sum into the output range
    always_comb begin
        mix_next = OW'(acc);
        if (acc > SAT_MAX) begin
            mix_next = {1'b0, {(OW-1){1'b1}}};
        end else if (acc < SAT_MIN) begin
            mix_next = {1'b1, {(OW-1){1'b0}}};
        end
    end
`else
    // Average over the voice count; the result always fits the output width
    assign mix_next = OW'(acc >>> LOG_N);
`endif

    // Frame FSM, accumulator and status registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            osc_index   <= IW'(N_WAVEGENS);
            acc         <= '0;
            mix_out     <= '0;
            mix_valid   <= 1'b0;
            active_mask <= '0;
            overrun     <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            if (ovr_clear_c) begin
                overrun <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        state     <= SWEEP;
                        osc_index <= '0;
                        acc       <= '0;
                    end
                end
                SWEEP: begin
                    if (sample_tick) begin
                        overrun <= 1'b1;
                    end
                    acc                           <= acc + voice_term;
                    active_mask[osc_index[VW-1:0]] <= osc_enabled;
                    if (osc_index == IW'(N_WAVEGENS - 1)) begin
                        state     <= PUBLISH;
                        osc_index <= IW'(N_WAVEGENS);
                    end else begin
                        osc_index <= osc_index + IW'(1);
                    end
                end
                PUBLISH: begin
                    if (sample_tick) begin
                        overrun <= 1'b1;
                    end
                    mix_out   <= mix_next;
                    mix_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    osc_index <= IW'(N_WAVEGENS);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wavegen_sequencer.sv
// Self-checking bench for wavegen_sequencer with a stubbed oscillator bank.
`ifndef FIXED_POINT
`include "constants.svh"
`endif

module tb_wavegen_sequencer;
    import shape_pkg::*;
    import protocol_pkg::*;

    localparam int unsigned N    = 4;
    localparam int unsigned W    = 24;
    localparam int unsigned OW   = W + `FIXED_POINT;
    localparam int unsigned LOGN = $clog2(N);

    logic                 clk;
    logic                 rstn;
    logic                 sample_tick;
    logic                 wr_en;
    logic [1:0]           wr_voice;
    logic [2:0]           wr_field;
    logic [31:0]          wr_data;
    logic [2:0]           osc_index;
    logic                 osc_enable;
    logic [7:0]           osc_cmds;
    logic [31:0]          osc_freq;
    logic [W-1:0]         osc_amplitude;
    wave_shape            osc_shape;
    logic signed [OW-1:0] osc_out;
    logic                 osc_enabled;
    logic signed [OW-1:0] mix_out;
    logic                 mix_valid;
    logic [N-1:0]         active_mask;
    logic                 overrun;

    // Oscillator stub: per-voice sample and envelope flag, zero on idle slot
    logic signed [OW-1:0] stub_out [N];
    logic                 stub_en  [N];
    assign osc_out     = (osc_index < 3'(N)) ? stub_out[osc_index[1:0]] : '0;
    assign osc_enabled = (osc_index < 3'(N)) ? stub_en[osc_index[1:0]] : 1'b0;

    wavegen_sequencer #(.WIDTH(W), .N_WAVEGENS(N)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .sample_tick   (sample_tick),
        .wr_en         (wr_en),
        .wr_voice      (wr_voice),
        .wr_field      (wr_field),
        .wr_data       (wr_data),
        .osc_index     (osc_index),
        .osc_enable    (osc_enable),
        .osc_cmds      (osc_cmds),
        .osc_freq      (osc_freq),
        .osc_amplitude (osc_amplitude),
        .osc_shape     (osc_shape),
        .osc_out       (osc_out),
        .osc_enabled   (osc_enabled),
        .mix_out       (mix_out),
        .mix_valid     (mix_valid),
        .active_mask   (active_mask),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model of the host-visible voice parameters
    logic         en_m   [N];
    logic [31:0]  freq_m [N];
    logic [W-1:0] amp_m  [N];
    wave_shape    shape_m[N];
    logic [7:0]   pend_m [N];
    logic [7:0]   exp_cmd[N];

    // What the bench observed on the oscillator port during the last frame
    logic [7:0]   seen_cmd  [N];
    logic [31:0]  seen_freq [N];
    logic [W-1:0] seen_amp  [N];
    wave_shape    seen_shape[N];
    logic         seen_en   [N];
    int           seen_lat;
    bit           seen_order_bad;

    task automatic model_reset();
        for (int v = 0; v < int'(N); v++) begin
            en_m[v] = 1'b0; freq_m[v] = '0; amp_m[v] = '0; shape_m[v] = SAWTOOTH; pend_m[v] = '0;
        end
    endtask

    task automatic host_write(input int v, input voice_field_t f, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_voice = 2'(v); wr_field = f; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        case (f)
            FREQ:    freq_m[v]  = d;
            AMP:     amp_m[v]   = d[W-1:0];
            SHAPE:   shape_m[v] = wave_shape'(d[1:0]);
            ENABLE:  en_m[v]    = d[0];
            CMD:     pend_m[v]  = pend_m[v] | d[7:0];
            default: ;
        endcase
    endtask

    // Expected mix: sum of enabled voices, then averaged or clipped
    function automatic logic signed [OW-1:0] exp_mix();
        longint s = 0;
        for (int v = 0; v < int'(N); v++) if (en_m[v]) s += longint'(stub_out[v]);
`ifdef MIX_SATURATE_EN
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
`else
        s = s >>> LOGN;
`endif
        return OW'(s);
    endfunction

    function automatic logic [N-1:0] exp_mask();
        logic [N-1:0] m;
        for (int v = 0; v < int'(N); v++) m[v] = stub_en[v];
        return m;
    endfunction

    // One frame: tick, record every addressed slot, wait (bounded) for mix_valid.
    // Optionally issue a CMD write to voice inj_k on its own slot-ending edge.
    task automatic run_frame(input bit inj, input int inj_k, input logic [7:0] inj_d);
        for (int v = 0; v < int'(N); v++) begin
            seen_cmd[v] = 8'hEE; seen_freq[v] = 32'hDEAD_BEEF; seen_amp[v] = '1;
            seen_shape[v] = SINE; seen_en[v] = 1'bx; exp_cmd[v] = pend_m[v];
        end
        seen_lat = -1;
        seen_order_bad = 1'b0;
        @(negedge clk);
        sample_tick = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            sample_tick = 1'b0;
            if (inj && k == inj_k) begin
                wr_en = 1'b1; wr_voice = 2'(inj_k); wr_field = CMD; wr_data = {24'h0, inj_d};
            end else begin
                wr_en = 1'b0;
            end
            if (osc_index < 3'(N)) begin
                if (int'(osc_index) != k) seen_order_bad = 1'b1;
                seen_cmd[osc_index[1:0]]   = osc_cmds;
                seen_freq[osc_index[1:0]]  = osc_freq;
                seen_amp[osc_index[1:0]]   = osc_amplitude;
                seen_shape[osc_index[1:0]] = osc_shape;
                seen_en[osc_index[1:0]]    = osc_enable;
            end
            if (mix_valid) begin
                seen_lat = k;
                break;
            end
        end
        wr_en = 1'b0;
        for (int v = 0; v < int'(N); v++) pend_m[v] = '0;
        if (inj) pend_m[inj_k] = inj_d;
    endtask

    task automatic test_reset();
        rstn = 1'b0; sample_tick = 1'b0; wr_en = 1'b0; wr_voice = '0; wr_field = '0; wr_data = '0;
        for (int v = 0; v < int'(N); v++) begin stub_out[v] = '0; stub_en[v] = 1'b0; end
        model_reset();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (osc_index !== 3'd4) begin errors++; $display("FAIL reset_index: got %0d want 4", osc_index); end
        checks++; if (mix_out !== '0) begin errors++; $display("FAIL reset_mix: got %0d want 0", mix_out); end
        checks++; if (active_mask !== '0) begin errors++; $display("FAIL reset_mask: got %b want 0000", active_mask); end
        checks++; if (mix_valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_flags: valid=%b ovr=%b want 0 0", mix_valid, overrun); end
        checks++; if (osc_freq !== '0 || osc_enable !== 1'b0 || osc_shape !== SAWTOOTH) begin
            errors++; $display("FAIL reset_idle_outputs: freq=%0h en=%b shape=%0d want 0 0 0", osc_freq, osc_enable, osc_shape); end
    endtask

    task automatic test_mix();
        logic signed [OW-1:0] want;
        for (int v = 0; v < int'(N); v++) begin host_write(v, ENABLE, 32'h1); stub_en[v] = 1'b1; end
        stub_out[0] = 1000; stub_out[1] = 2000; stub_out[2] = -500; stub_out[3] = 0;
`ifdef MIX_SATURATE_EN
        want = 2500;
`else
        want = 625;
`endif
        run_frame(1'b0, 0, 8'h00);
        checks++; if (seen_lat != 5) begin errors++; $display("FAIL mix_latency: got %0d want 5", seen_lat); end
        checks++; if (mix_out !== want) begin errors++; $display("FAIL mix_value: got %0d want %0d", mix_out, want); end
        @(negedge clk);
        checks++; if (mix_valid !== 1'b0 || mix_out !== want) begin
            errors++; $display("FAIL mix_pulse: valid=%b mix=%0d want 0 %0d", mix_valid, mix_out, want); end
    endtask

    task automatic test_saturation();
        for (int v = 0; v < int'(N); v++) stub_out[v] = {1'b0, {(OW-1){1'b1}}};
        run_frame(1'b0, 0, 8'h00);
        checks++; if (mix_out !== {1'b0, {(OW-1){1'b1}}}) begin errors++; $display("FAIL sat_max: got %0h want 7fffffff", mix_out); end
        for (int v = 0; v < int'(N); v++) stub_out[v] = {1'b1, {(OW-1){1'b0}}};
        run_frame(1'b0, 0, 8'h00);
        checks++; if (mix_out !== {1'b1, {(OW-1){1'b0}}}) begin errors++; $display("FAIL sat_min: got %0h want 80000000", mix_out); end
    endtask

    task automatic test_one_shot();
        host_write(2, CMD, 32'h01);
        run_frame(1'b0, 0, 8'h00);
        checks++; if (seen_cmd[2] !== 8'h01) begin errors++; $display("FAIL cmd_slot: got %0h want 01", seen_cmd[2]); end
        checks++; if (seen_cmd[0] !== 8'h00 || seen_cmd[1] !== 8'h00 || seen_cmd[3] !== 8'h00) begin
            errors++; $display("FAIL cmd_other_slots: got %0h %0h %0h want 00", seen_cmd[0], seen_cmd[1], seen_cmd[3]); end
        run_frame(1'b0, 0, 8'h00);
        checks++; if (seen_cmd[2] !== 8'h00) begin errors++; $display("FAIL cmd_cleared: got %0h want 00", seen_cmd[2]); end
        run_frame(1'b1, 2, 8'h04);
        checks++; if (seen_cmd[2] !== exp_cmd[2]) begin errors++; $display("FAIL cmd_inject_frame: got %0h want %0h", seen_cmd[2], exp_cmd[2]); end
        run_frame(1'b0, 0, 8'h00);
        checks++; if (seen_cmd[2] !== 8'h04) begin errors++; $display("FAIL cmd_reissued: got %0h want 04", seen_cmd[2]); end
        run_frame(1'b0, 0, 8'h00);
        for (int v = 0; v < int'(N); v++) begin
            checks++; if (seen_cmd[v] !== exp_cmd[v]) begin errors++; $display("FAIL cmd_final v%0d: got %0h want %0h", v, seen_cmd[v], exp_cmd[v]); end
        end
    endtask

    task automatic test_overrun();
        int pulses = 0;
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (mix_valid) pulses++;
            @(negedge clk);
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL overrun_pulses: got %0d want 1", pulses); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", overrun); end
        host_write(0, CLR_OVR, 32'h0);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b want 0", overrun); end
    endtask

    task automatic test_active();
        for (int v = 0; v < int'(N); v++) stub_en[v] = (v == 1);
        for (int v = 0; v < int'(N); v++) stub_out[v] = OW'(100 * (v + 1));
        run_frame(1'b0, 0, 8'h00);
        checks++; if (active_mask !== 4'b0010) begin errors++; $display("FAIL active_mask: got %b want 0010", active_mask); end
        host_write(1, ENABLE, 32'h0);
        stub_out[1] = 100000;
        run_frame(1'b0, 0, 8'h00);
        checks++; if (mix_out !== exp_mix()) begin errors++; $display("FAIL disabled_excluded: got %0d want %0d", mix_out, exp_mix()); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            for (int v = 0; v < int'(N); v++) begin
                host_write(v, FREQ, $urandom);
                host_write(v, AMP, $urandom);
                host_write(v, SHAPE, 32'($urandom_range(0, 3)));
                host_write(v, ENABLE, 32'($urandom_range(0, 1)));
                if ($urandom_range(0, 2) == 0) host_write(v, CMD, 32'($urandom_range(0, 255)));
                stub_out[v] = OW'($urandom);
                stub_en[v]  = 1'($urandom_range(0, 1));
            end
            run_frame(1'b0, 0, 8'h00);
            checks++; if (seen_lat != int'(N) + 1 || seen_order_bad) begin
                errors++; $display("FAIL rand_sweep it%0d: latency %0d order_bad %0d want %0d 0", it, seen_lat, seen_order_bad, N + 1); end
            checks++; if (mix_out !== exp_mix()) begin errors++; $display("FAIL rand_mix it%0d: got %0d want %0d", it, mix_out, exp_mix()); end
            checks++; if (active_mask !== exp_mask()) begin errors++; $display("FAIL rand_mask it%0d: got %b want %b", it, active_mask, exp_mask()); end
            for (int v = 0; v < int'(N); v++) begin
                checks++;
                if (seen_freq[v] !== freq_m[v] || seen_amp[v] !== amp_m[v] || seen_shape[v] !== shape_m[v]
                    || seen_en[v] !== en_m[v] || seen_cmd[v] !== exp_cmd[v]) begin
                    errors++;
                    $display("FAIL rand_params it%0d v%0d: got f=%0h a=%0h s=%0d e=%b c=%0h want f=%0h a=%0h s=%0d e=%b c=%0h",
                             it, v, seen_freq[v], seen_amp[v], seen_shape[v], seen_en[v], seen_cmd[v],
                             freq_m[v], amp_m[v], shape_m[v], en_m[v], exp_cmd[v]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        for (int v = 0; v < int'(N); v++) begin host_write(v, ENABLE, 32'h1); stub_en[v] = 1'b1; stub_out[v] = 1000; end
        run_frame(1'b0, 0, 8'h00);
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++; if (osc_index !== 3'd4) begin errors++; $display("FAIL async_reset_index: got %0d want 4", osc_index); end
        checks++; if (mix_out !== '0 || active_mask !== '0) begin
            errors++; $display("FAIL async_reset_state: mix=%0d mask=%b want 0 0000", mix_out, active_mask); end
        checks++; if (osc_freq !== '0 || mix_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset_outputs: freq=%0h valid=%b want 0 0", osc_freq, mix_valid); end
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        run_frame(1'b0, 0, 8'h00);
        checks++; if (mix_out !== exp_mix() || seen_en[0] !== 1'b0) begin
            errors++; $display("FAIL post_reset_frame: mix=%0d en0=%b want %0d 0", mix_out, seen_en[0], exp_mix()); end
    endtask

    initial begin
        test_reset();
        test_mix();
        test_saturation();
        test_one_shot();
        test_overrun();
        test_active();
        test_random();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
